// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: data port has priority, the grant is locked until
// the address handshake, and an in-order id FIFO routes each dataok back to its issuer.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = $clog2(OUTSTANDING) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addrok,
  output logic        inst_dataok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addrok,
  output logic        data_dataok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addrok,
  input  logic        m_dataok
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } lock_e;

  lock_e                  lock_r;
  logic [OUTSTANDING-1:0] src_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic win_inst_s;
  logic win_data_s;
  logic win_req_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic head_src_s;

  // Winner selection: data beats inst when free, a lock pins the winner.
  always_comb begin
    win_inst_s = 1'b0;
    win_data_s = 1'b0;
    case (lock_r)
      FREE: begin
        if (data_req) begin
          win_data_s = 1'b1;
        end else if (inst_req) begin
          win_inst_s = 1'b1;
        end else begin
          win_inst_s = 1'b0;
          win_data_s = 1'b0;
        end
      end
      LOCK_I:  win_inst_s = 1'b1;
      LOCK_D:  win_data_s = 1'b1;
      default: begin
        win_inst_s = 1'b0;
        win_data_s = 1'b0;
      end
    endcase
  end

  assign win_req_s  = (win_inst_s & inst_req) | (win_data_s & data_req);
  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign head_src_s = src_r[rd_ptr_r];
  assign pop_s      = m_dataok & ~empty_s & ~reset;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign m_req      = win_req_s & (~full_s | pop_s) & ~reset;
  assign push_s     = m_req & m_addrok;

  assign inst_addrok = push_s & win_inst_s;
  assign data_addrok = push_s & win_data_s;
  assign inst_dataok = pop_s & ~head_src_s;
  assign data_dataok = pop_s & head_src_s;
  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;

  // Master request fields follow the winner; data fields when nobody wins.
  always_comb begin
    if (win_inst_s) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wstrb = inst_wstrb;
      m_wdata = inst_wdata;
    end else begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wstrb = data_wstrb;
      m_wdata = data_wdata;
    end
  end

  // Lock state, source-id FIFO and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r   <= FREE;
      src_r    <= {OUTSTANDING{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      case (lock_r)
        FREE: begin
          if (m_req && !m_addrok) begin
            lock_r <= win_data_s ? LOCK_D : LOCK_I;
          end
        end
        LOCK_I, LOCK_D: begin
          if (push_s) begin
            lock_r <= FREE;
          end
        end
        default: lock_r <= FREE;
      endcase

      if (push_s) begin
        src_r[wr_ptr_r] <= win_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: issued requests push their expected
// source onto a scoreboard queue, each returned dataok pops and checks routing.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addrok, inst_dataok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addrok, data_dataok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_addrok, m_dataok;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  sram_like_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addrok(inst_addrok),
    .inst_dataok(inst_dataok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addrok(data_addrok),
    .data_dataok(data_dataok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addrok(m_addrok), .m_dataok(m_dataok)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; data_req = 1'b0;
    m_addrok = 1'b0; m_dataok = 1'b0;
  endtask

  // Return one transaction: the head of the scoreboard decides which dataok must fire.
  task automatic ret(input logic [31:0] rd);
    logic src;
    m_dataok = 1'b1;
    m_rdata  = rd;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val("stray_i_dok", {31'd0, inst_dataok}, 32'd0);
      check_val("stray_d_dok", {31'd0, data_dataok}, 32'd0);
    end else begin
      src = exp_q.pop_front();
      check_val("i_dok", {31'd0, inst_dataok}, {31'd0, ~src});
      check_val("d_dok", {31'd0, data_dataok}, {31'd0, src});
      check_val(src ? "d_rdata" : "i_rdata", src ? data_rdata : inst_rdata, rd);
    end
    next_cycle();
    m_dataok = 1'b0;
  endtask

  task automatic accept_inst(input logic [31:0] addr);
    inst_req  = 1'b1;
    inst_addr = addr;
    m_addrok  = 1'b1;
    @(negedge clk);
    check_val("i_m_req", {31'd0, m_req}, 32'd1);
    check_val("i_m_addr", m_addr, addr);
    check_val("i_addrok", {31'd0, inst_addrok}, 32'd1);
    check_val("i_d_addrok", {31'd0, data_addrok}, 32'd0);
    exp_q.push_back(1'b0);
    next_cycle();
    inst_req = 1'b0;
    m_addrok = 1'b0;
  endtask

  task automatic accept_data(input logic [31:0] addr, input logic wr);
    data_req  = 1'b1;
    data_addr = addr;
    data_wr   = wr;
    m_addrok  = 1'b1;
    @(negedge clk);
    check_val("d_m_addr", m_addr, addr);
    check_val("d_m_wr", {31'd0, m_wr}, {31'd0, wr});
    check_val("d_addrok", {31'd0, data_addrok}, 32'd1);
    check_val("d_i_addrok", {31'd0, inst_addrok}, 32'd0);
    exp_q.push_back(1'b1);
    next_cycle();
    data_req = 1'b0;
    m_addrok = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_val({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
    check_val({tag, "_addrok"}, {30'd0, inst_addrok, data_addrok}, 32'd0);
    check_val({tag, "_dataok"}, {30'd0, inst_dataok, data_dataok}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wstrb = 4'hf; inst_wdata = 32'h0;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wstrb = 4'hf; data_wdata = 32'h0;
    m_rdata = 32'h0;
    next_cycle();
    // Everything asserted during reset must be masked.
    inst_req = 1'b1; data_req = 1'b1; m_addrok = 1'b1; m_dataok = 1'b1;
    check_reset_outputs("rst0");
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    check_val("rst0_count", 32'(dut.count_r), 32'd0);

    // 1: single inst read
    accept_inst(32'hbfc0_0000);
    check_val("t1_count1", 32'(dut.count_r), 32'd1);
    ret(32'h3c1d_0000);
    check_val("t1_count0", 32'(dut.count_r), 32'd0);

    // 2: simultaneous requests, data first then inst
    inst_req = 1'b1; inst_addr = 32'hbfc0_0004;
    data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b1; data_wstrb = 4'hf;
    data_wdata = 32'h1234_5678; m_addrok = 1'b1;
    @(negedge clk);
    check_val("t2_d_addrok", {31'd0, data_addrok}, 32'd1);
    check_val("t2_i_addrok", {31'd0, inst_addrok}, 32'd0);
    check_val("t2_m_addr", m_addr, 32'h8000_1000);
    check_val("t2_m_wdata", m_wdata, 32'h1234_5678);
    exp_q.push_back(1'b1);
    next_cycle();
    data_req = 1'b0;
    data_wr  = 1'b0;
    @(negedge clk);
    check_val("t2_i_addrok2", {31'd0, inst_addrok}, 32'd1);
    check_val("t2_m_addr2", m_addr, 32'hbfc0_0004);
    exp_q.push_back(1'b0);
    next_cycle();
    idle_inputs();
    ret(32'h0000_0001);
    ret(32'h0000_0002);

    // 3: lock holds inst for 3 cycles while data arrives
    inst_req = 1'b1; inst_addr = 32'hbfc0_0100; data_addr = 32'h8000_2000;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) data_req = 1'b1;
      m_addrok = (c == 2);
      @(negedge clk);
      check_val("t3_m_req", {31'd0, m_req}, 32'd1);
      check_val("t3_m_addr", m_addr, 32'hbfc0_0100);
      check_val("t3_d_addrok", {31'd0, data_addrok}, 32'd0);
      check_val("t3_i_addrok", {31'd0, inst_addrok}, {31'd0, m_addrok});
      next_cycle();
    end
    exp_q.push_back(1'b0);
    inst_req = 1'b0;
    m_addrok = 1'b1;
    @(negedge clk);
    check_val("t3_d_after", {31'd0, data_addrok}, 32'd1);
    check_val("t3_m_addr_d", m_addr, 32'h8000_2000);
    exp_q.push_back(1'b1);
    next_cycle();
    idle_inputs();
    ret(32'h0000_0003);
    ret(32'h0000_0004);

    // 4: fill to OUTSTANDING, then pop+push in the same cycle
    for (int k = 0; k < 4; k++) accept_inst(32'hbfc0_0200 + 32'(k * 4));
    check_val("t4_count_full", 32'(dut.count_r), 32'd4);
    inst_req = 1'b1; inst_addr = 32'hbfc0_0300; m_addrok = 1'b1;
    @(negedge clk);
    check_val("t4_full_m_req", {31'd0, m_req}, 32'd0);
    check_val("t4_full_addrok", {31'd0, inst_addrok}, 32'd0);
    next_cycle();
    check_val("t4_count_hold", 32'(dut.count_r), 32'd4);
    m_dataok = 1'b1; m_rdata = 32'h0000_0005;
    @(negedge clk);
    check_val("t4_pp_m_req", {31'd0, m_req}, 32'd1);
    check_val("t4_pp_addrok", {31'd0, inst_addrok}, 32'd1);
    check_val("t4_pp_i_dok", {31'd0, inst_dataok}, {31'd0, ~exp_q.pop_front()});
    exp_q.push_back(1'b0);
    next_cycle();
    idle_inputs();
    check_val("t4_count_pp", 32'(dut.count_r), 32'd4);
    for (int k = 0; k < 4; k++) ret(32'h0000_0010 + 32'(k));
    check_val("t4_count_empty", 32'(dut.count_r), 32'd0);

    // 5: ordering D, I, D
    accept_data(32'h8000_3000, 1'b0);
    accept_inst(32'hbfc0_0400);
    accept_data(32'h8000_3004, 1'b1);
    ret(32'haaaa_0001);
    ret(32'hbbbb_0002);
    ret(32'hcccc_0003);

    // 6: reset with two outstanding, then a stray dataok
    accept_inst(32'hbfc0_0500);
    accept_data(32'h8000_4000, 1'b0);
    check_val("t6_count2", 32'(dut.count_r), 32'd2);
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; m_addrok = 1'b1; m_dataok = 1'b1;
    check_reset_outputs("rst1");
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    exp_q.delete();
    check_val("t6_count0", 32'(dut.count_r), 32'd0);
    ret(32'hdead_beef);
    check_val("t6_no_underflow", 32'(dut.count_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
